out_frame_arbiter: RTL and testbench
====================================

# out_frame_arbiter

Controller that owns the single-port output frame memory written by the pipeline's GP (opcode 10) pixel stores. It buffers pixel writes from the MEM stage in a small FIFO, generates sequential frame addresses, and arbitrates the memory port between those writes and an external readout client (display or dump engine). It also tracks frame completion and supports a synchronous frame restart.

## Interface
- DEPTH, 153600: pixels per frame (one byte each)
- ADDR_W, 18: memory address width; must satisfy 2^ADDR_W ≥ DEPTH
- DATA_W, 8: pixel width
- FIFO_DEPTH, 4: write-buffer entries (power of two, ≥ 2)

- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous frame restart, one-cycle pulse
- gp_valid  in  1  MEM stage presents a pixel
- gp_data  in  DATA_W  pixel value (AluResult[7:0])
- gp_ready  out  1  pixel accepted when gp_valid & gp_ready
- rd_req  in  1  readout request, held until granted
- rd_addr  in  ADDR_W  readout address
- rd_gnt  out  1  request accepted this cycle
- rd_valid  out  1  rd_data valid
- rd_data  out  DATA_W  read pixel
- mem_en  out  1  memory access strobe
- mem_we  out  1  write when 1, read when 0 (qualified by mem_en)
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  synchronous RAM read data, valid 1 cycle after read strobe
- pix_count  out  ADDR_W  pixels written to memory this frame
- frame_done  out  1  all DEPTH pixels written

## Operation
- States: FILL, DONE. Reset and clear go to FILL.
- accepted counter counts pushes. gp_ready = (state==FILL) & FIFO not full & accepted < DEPTH & !clear.
- Each cycle the port goes to at most one requester:
  - If the FIFO is full, a pending write wins.
  - Otherwise, if rd_req is high, the read wins (rd_gnt=1).
  - Otherwise, if the FIFO is not empty, the write wins.
- Write grant: pop FIFO head. Drive mem_en=1, mem_we=1, mem_addr=pix_count, mem_wdata=head. Then pix_count increments.
- Read grant with rd_addr < DEPTH: mem_en=1, mem_we=0, mem_addr=rd_addr. rd_data = mem_rdata on the next cycle, with rd_valid=1.
- Read grant with rd_addr ≥ DEPTH: no memory access (mem_en=0). Next cycle rd_valid=1 and rd_data=0.
- When pix_count reaches DEPTH: state goes to DONE and frame_done=1. pix_count saturates at DEPTH; it never wraps.
- In DONE, reads are still served and gp_ready=0.
- clear:
  - Flushes the FIFO and zeros pix_count and accepted.
  - Drops frame_done and returns to FILL.
  - No memory write is issued in the clear cycle.
  - A read granted in the clear cycle completes normally.
- Simultaneous push and pop on the FIFO in one cycle are both honoured; occupancy is unchanged.

## Timing
- Reset values:
  - gp_ready=1, rd_gnt=0, rd_valid=0, rd_data=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - pix_count=0, frame_done=0, state FILL, FIFO empty.
- Memory-side outputs and rd_gnt are combinational from registered state and the current rd_req.
- rd_valid and rd_data are registered.
- Push to memory write: at least 1 cycle (the entry is registered in the FIFO first).
- Read latency: grant cycle N gives rd_valid in cycle N+1.
- frame_done rises in the cycle after the DEPTH-th write strobe.
- Write starvation is bounded. While rd_req stays high, at most FIFO_DEPTH reads are granted before a write is forced (at FIFO full).
- Reset mid-operation discards the FIFO contents and any in-flight read (rd_valid=0).

## Structure
- Shared package out_mem_pkg holds:
  - the state enum (FILL, DONE)
  - OUT_DEPTH=153600
  - OUT_ADDR_W=18
  - OPC_GP=5'd10, so the MEM stage derives gp_valid from the same constant
- One sub-module: pix_fifo, a synchronous FIFO with parameters DATA_W and FIFO_DEPTH, and ports push, pop, flush, full, empty, head.
- The arbiter, counters and state register live in the top module.

## Test plan
- Reset, then push 3 pixels 0x11, 0x22, 0x33 with rd_req low -> writes to addresses 0, 1, 2 on consecutive cycles starting 1 cycle after the first push; pix_count=3.
- Hold rd_req high with rd_addr=0 while pushing continuously -> 4 reads are granted, then the FIFO fills and a write is forced; rd_data=0x11 one cycle after each grant; no pixel is lost.
- Use DEPTH=8 and push 10 pixels -> gp_ready falls after the 8th accept; frame_done=1 one cycle after the 8th write; addresses never exceed 7.
- In DONE, read rd_addr=8 with DEPTH=8 -> mem_en=0, and next cycle rd_valid=1 with rd_data=0.
- Pulse clear with 2 pixels still in the FIFO and gp_valid high -> no write that cycle, push ignored, then pix_count=0, frame_done=0, and the next pixel is written to address 0.
- Assert rst_n low between a read grant and the following cycle -> rd_valid stays 0, and all outputs take their reset values immediately.

Source files
------------

// File: rtl/out_mem_pkg.sv
// Shared constants and state encoding for the output frame memory path.
// The MEM stage uses OPC_GP to qualify gp_valid against the same opcode.
package out_mem_pkg;

    localparam int          OUT_DEPTH  = 153600;
    localparam int          OUT_ADDR_W = 18;
    localparam logic [4:0]  OPC_GP     = 5'd10;

    typedef enum logic {
        FILL = 1'b0,
        DONE = 1'b1
    } frame_state_e;

endpackage

// File: rtl/pix_fifo.sv
// Small synchronous write buffer between the MEM stage and the frame memory.
// Push and pop in the same cycle are both honoured; flush empties it at once.
module pix_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    input  logic              flush,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [PTR_W:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]      rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic                do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head    = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= din;
        end
    end

endmodule

// File: rtl/out_frame_arbiter.sv
// Owns the single-port output frame memory: buffers GP pixel stores, writes them
// to sequential addresses, and shares the port with an external readout client.
module out_frame_arbiter
    import out_mem_pkg::*;
#(
    parameter int DEPTH      = OUT_DEPTH,
    parameter int ADDR_W     = OUT_ADDR_W,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              gp_valid,
    input  logic [DATA_W-1:0] gp_data,
    output logic              gp_ready,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] pix_count,
    output logic              frame_done
);

    // One extra bit so the counters can hold DEPTH even when DEPTH == 2^ADDR_W.
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    frame_state_e        state_q, state_d;
    logic [ADDR_W:0]     pix_q, pix_d;
    logic [ADDR_W:0]     acc_q, acc_d;
    logic                rd_valid_q, rd_valid_d;
    logic                rd_oor_q, rd_oor_d;

    logic                fifo_full, fifo_empty;
    logic [DATA_W-1:0]   fifo_head;
    logic                push, wr_gnt, rd_in_range, wr_ok;

    pix_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (gp_data),
        .pop   (wr_gnt),
        .flush (clear),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    assign gp_ready    = (state_q == FILL) && !fifo_full && (acc_q < DEPTH_C) && !clear;
    assign push        = gp_valid && gp_ready;
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_C);
    // A clear cycle never writes; the saturation guard keeps pix_count from passing DEPTH.
    assign wr_ok       = !fifo_empty && !clear && (pix_q < DEPTH_C);

    always_comb begin
        wr_gnt     = 1'b0;
        rd_gnt     = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        state_d    = state_q;
        pix_d      = pix_q;
        acc_d      = acc_q;

        // A full FIFO forces a write, bounding how long reads can starve it.
        if (fifo_full && wr_ok) begin
            wr_gnt = 1'b1;
        end else if (rd_req) begin
            rd_gnt = 1'b1;
        end else if (wr_ok) begin
            wr_gnt = 1'b1;
        end

        if (wr_gnt) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = pix_q[ADDR_W-1:0];
            mem_wdata = fifo_head;
            pix_d     = pix_q + 1'b1;
        end else if (rd_gnt && rd_in_range) begin
            mem_en    = 1'b1;
            mem_addr  = rd_addr;
        end

        if (push) acc_d = acc_q + 1'b1;

        case (state_q)
            FILL:    if (pix_d == DEPTH_C) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = FILL;
        endcase

        if (clear) begin
            pix_d   = '0;
            acc_d   = '0;
            state_d = FILL;
        end

        rd_valid_d = rd_gnt;
        rd_oor_d   = rd_gnt && !rd_in_range;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FILL;
            pix_q      <= '0;
            acc_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_oor_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pix_q      <= pix_d;
            acc_q      <= acc_d;
            rd_valid_q <= rd_valid_d;
            rd_oor_q   <= rd_oor_d;
        end
    end

    // RAM output register supplies the data; out-of-range reads return zero.
    assign rd_valid   = rd_valid_q;
    assign rd_data    = (rd_valid_q && !rd_oor_q) ? mem_rdata : '0;
    assign pix_count  = pix_q[ADDR_W-1:0];
    assign frame_done = (state_q == DONE);

endmodule

// File: tb/tb_out_frame_arbiter.sv
// Directed bench for out_frame_arbiter with DEPTH=8 and a behavioural sync RAM.
module tb_out_frame_arbiter;

    localparam int DEPTH = 8;
    localparam int AW    = 18;
    localparam int DW    = 8;

    logic          clk = 1'b0;
    logic          rst_n, clear, gp_valid, gp_ready, rd_req, rd_gnt, rd_valid;
    logic [DW-1:0] gp_data, rd_data, mem_wdata, mem_rdata;
    logic [AW-1:0] rd_addr, mem_addr, pix_count;
    logic          mem_en, mem_we, frame_done;
    logic [DW-1:0] ram [256];

    int checks = 0;
    int errors = 0;

    out_frame_arbiter #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .gp_valid(gp_valid), .gp_data(gp_data), .gp_ready(gp_ready),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .pix_count(pix_count), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = '0;
        mem_rdata = '0;
    end

    always @(posedge clk) begin
        if (mem_en && mem_we)  ram[mem_addr[7:0]] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= ram[mem_addr[7:0]];
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clear = 0; gp_valid = 0; gp_data = '0; rd_req = 0; rd_addr = '0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        #2;
        checks++; if (gp_ready !== 1'b1) begin errors++; $display("FAIL reset_gp_ready: got %b want 1", gp_ready); end
        checks++; if ({rd_gnt, rd_valid, mem_en, mem_we, frame_done} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b want 00000", {rd_gnt, rd_valid, mem_en, mem_we, frame_done}); end
        checks++; if ({rd_data, mem_wdata} !== 16'h0) begin errors++; $display("FAIL reset_data: got %h want 0000", {rd_data, mem_wdata}); end
        checks++; if ({mem_addr, pix_count} !== '0) begin errors++; $display("FAIL reset_addr: mem_addr %0d pix %0d want 0 0", mem_addr, pix_count); end
        next_cycle();
        next_cycle();
        rst_n = 1;
        next_cycle();
    endtask

    task automatic test_writes();
        logic [DW-1:0] px [3];
        px[0] = 8'h11; px[1] = 8'h22; px[2] = 8'h33;
        // Cycle 0: push only, FIFO still empty so no write.
        gp_valid = 1; gp_data = px[0];
        #2;
        checks++; if (gp_ready !== 1'b1 || mem_en !== 1'b0) begin errors++; $display("FAIL wr_first: ready %b en %b want 1 0", gp_ready, mem_en); end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            gp_valid = (i < 2); gp_data = (i < 2) ? px[i+1] : 8'h00;
            #2;
            checks++;
            if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== AW'(i) || mem_wdata !== px[i]) begin
                errors++;
                $display("FAIL wr_seq%0d: en %b we %b addr %0d data %h want 1 1 %0d %h", i, mem_en, mem_we, mem_addr, mem_wdata, i, px[i]);
            end
        end
        next_cycle();
        #2;
        checks++; if (mem_en !== 1'b0 || pix_count !== AW'(3)) begin errors++; $display("FAIL wr_count: en %b pix %0d want 0 3", mem_en, pix_count); end
        next_cycle();
    endtask

    // Continuous pushes with rd_req held: reads win until the FIFO fills, then the
    // accepted limit (8) stops input and the frame completes at address 7.
    task automatic test_starvation_and_frame();
        logic [11:0] gv_t, rq_t, gpr_e, gnt_e, wr_e, rv_e;
        logic [AW-1:0] addr_e [12];
        logic [DW-1:0] wd_e [12];
        logic [DW-1:0] nxt;
        gv_t  = 12'b0000_1111_1111;
        rq_t  = 12'b0000_1111_1111;
        gpr_e = 12'b0000_0010_1111;
        gnt_e = 12'b0000_1010_1111;
        wr_e  = 12'b0111_0101_0000;
        rv_e  = 12'b0001_0101_1110;
        for (int c = 0; c < 12; c++) begin addr_e[c] = '0; wd_e[c] = '0; end
        addr_e[4] = 3; wd_e[4] = 8'hA0;
        addr_e[6] = 4; wd_e[6] = 8'hA1;
        addr_e[8] = 5; wd_e[8] = 8'hA2;
        addr_e[9] = 6; wd_e[9] = 8'hA3;
        addr_e[10] = 7; wd_e[10] = 8'hA4;
        nxt = 8'hA0;
        for (int c = 0; c < 12; c++) begin
            gp_valid = gv_t[c]; gp_data = nxt; rd_req = rq_t[c]; rd_addr = '0;
            #2;
            checks++;
            if (gp_ready !== gpr_e[c] || rd_gnt !== gnt_e[c] || rd_valid !== rv_e[c] ||
                mem_en !== (wr_e[c] | gnt_e[c]) || mem_we !== wr_e[c]) begin
                errors++;
                $display("FAIL starve_ctl c%0d: rdy %b gnt %b rv %b en %b we %b want %b %b %b %b %b",
                         c, gp_ready, rd_gnt, rd_valid, mem_en, mem_we,
                         gpr_e[c], gnt_e[c], rv_e[c], wr_e[c] | gnt_e[c], wr_e[c]);
            end
            if (wr_e[c]) begin
                checks++;
                if (mem_addr !== addr_e[c] || mem_wdata !== wd_e[c]) begin
                    errors++;
                    $display("FAIL starve_wr c%0d: addr %0d data %h want %0d %h", c, mem_addr, mem_wdata, addr_e[c], wd_e[c]);
                end
            end
            if (rv_e[c]) begin
                checks++;
                if (rd_data !== 8'h11) begin errors++; $display("FAIL starve_rd c%0d: got %h want 11", c, rd_data); end
            end
            checks++;
            if (frame_done !== (c == 11)) begin errors++; $display("FAIL frame_done c%0d: got %b want %b", c, frame_done, c == 11); end
            if (gv_t[c] && gpr_e[c]) nxt = nxt + 1'b1;
            next_cycle();
        end
        idle_inputs();
        #2;
        checks++; if (pix_count !== AW'(8)) begin errors++; $display("FAIL pix_sat: got %0d want 8", pix_count); end
        checks++;
        if (ram[3] !== 8'hA0 || ram[4] !== 8'hA1 || ram[5] !== 8'hA2 || ram[6] !== 8'hA3 || ram[7] !== 8'hA4 || ram[8] !== 8'h00) begin
            errors++;
            $display("FAIL ram_contents: %h %h %h %h %h %h want a0 a1 a2 a3 a4 00", ram[3], ram[4], ram[5], ram[6], ram[7], ram[8]);
        end
        next_cycle();
    endtask

    task automatic test_done_reads();
        rd_req = 1; rd_addr = AW'(8);
        #2;
        checks++; if (rd_gnt !== 1'b1 || mem_en !== 1'b0 || gp_ready !== 1'b0) begin errors++; $display("FAIL oor_grant: gnt %b en %b rdy %b want 1 0 0", rd_gnt, mem_en, gp_ready); end
        next_cycle();
        rd_addr = AW'(7);
        #2;
        checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h00) begin errors++; $display("FAIL oor_data: valid %b data %h want 1 00", rd_valid, rd_data); end
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== AW'(7)) begin errors++; $display("FAIL done_read: en %b we %b addr %0d want 1 0 7", mem_en, mem_we, mem_addr); end
        next_cycle();
        idle_inputs();
        #2;
        checks++; if (rd_valid !== 1'b1 || rd_data !== 8'hA4) begin errors++; $display("FAIL done_data: valid %b data %h want 1 a4", rd_valid, rd_data); end
        next_cycle();
    endtask

    task automatic test_clear();
        clear = 1;
        #2;
        checks++; if (gp_ready !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL clr1: rdy %b en %b want 0 0", gp_ready, mem_en); end
        next_cycle();
        clear = 0; rd_req = 1; rd_addr = AW'(7); gp_valid = 1; gp_data = 8'hB0;
        #2;
        checks++; if (frame_done !== 1'b0 || pix_count !== '0 || gp_ready !== 1'b1 || rd_gnt !== 1'b1) begin errors++; $display("FAIL clr_restart: done %b pix %0d rdy %b gnt %b want 0 0 1 1", frame_done, pix_count, gp_ready, rd_gnt); end
        next_cycle();
        gp_data = 8'hB1;
        next_cycle();
        // Two pixels buffered; clear with a push attempt and no read.
        clear = 1; rd_req = 0; gp_data = 8'hB2;
        #2;
        checks++; if (mem_en !== 1'b0 || gp_ready !== 1'b0) begin errors++; $display("FAIL clr_nowrite: en %b rdy %b want 0 0", mem_en, gp_ready); end
        checks++; if (rd_valid !== 1'b1 || rd_data !== 8'hA4) begin errors++; $display("FAIL clr_prev_read: valid %b data %h want 1 a4", rd_valid, rd_data); end
        next_cycle();
        clear = 0; gp_data = 8'hC0;
        #2;
        checks++; if (mem_en !== 1'b0 || pix_count !== '0 || frame_done !== 1'b0 || gp_ready !== 1'b1) begin errors++; $display("FAIL clr_flushed: en %b pix %0d done %b rdy %b want 0 0 0 1", mem_en, pix_count, frame_done, gp_ready); end
        next_cycle();
        gp_valid = 0;
        #2;
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== '0 || mem_wdata !== 8'hC0) begin errors++; $display("FAIL clr_addr0: en %b we %b addr %0d data %h want 1 1 0 c0", mem_en, mem_we, mem_addr, mem_wdata); end
        next_cycle();
        #2;
        checks++; if (pix_count !== AW'(1)) begin errors++; $display("FAIL clr_count: got %0d want 1", pix_count); end
        next_cycle();
    endtask

    task automatic test_reset_midread();
        gp_valid = 1; gp_data = 8'hD0;
        next_cycle();
        gp_valid = 0; rd_req = 1; rd_addr = '0;
        #2;
        checks++; if (rd_gnt !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL mid_grant: gnt %b we %b want 1 0", rd_gnt, mem_we); end
        #2;
        rst_n = 0; rd_req = 0;
        #1;
        checks++; if ({rd_valid, mem_en, mem_we, frame_done, gp_ready} !== 5'b00001 || pix_count !== '0 || mem_addr !== '0) begin errors++; $display("FAIL mid_async: flags %b pix %0d addr %0d want 00001 0 0", {rd_valid, mem_en, mem_we, frame_done, gp_ready}, pix_count, mem_addr); end
        next_cycle();
        checks++; if (rd_valid !== 1'b0 || rd_data !== '0) begin errors++; $display("FAIL mid_rdvalid: valid %b data %h want 0 00", rd_valid, rd_data); end
        rst_n = 1;
        next_cycle();
        #2;
        checks++; if (mem_en !== 1'b0 || gp_ready !== 1'b1 || pix_count !== '0) begin errors++; $display("FAIL mid_discard: en %b rdy %b pix %0d want 0 1 0", mem_en, gp_ready, pix_count); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_writes();
        test_starvation_and_frame();
        test_done_reads();
        test_clear();
        test_reset_midread();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
